// File: rtl/mem_ctrl_pkg.sv
// Shared types, size codes and helpers for the unified byte-wide RAM port controller.
// Everything here is combinational and free of state.
package mem_ctrl_pkg;

  typedef logic [31:0] data_t;
  typedef logic [31:0] addr_t;

  localparam logic [5:0] MEM_SIZE_B = 6'd1;
  localparam logic [5:0] MEM_SIZE_H = 6'd2;
  localparam logic [5:0] MEM_SIZE_W = 6'd4;

  // addr[17:16] value selecting the memory-mapped IO window (0x30000 and up)
  localparam logic [1:0] RAM_IO_HI_DEFAULT = 2'b11;

  localparam data_t ZERO_WORD = 32'h0000_0000;
  localparam logic  TRUE      = 1'b1;
  localparam logic  FALSE     = 1'b0;

  // Anything that is not a byte or half-word access moves a full word.
  function automatic logic [2:0] beat_count(input logic [5:0] size);
    logic [2:0] n;
    if (size == MEM_SIZE_B)      n = 3'd1;
    else if (size == MEM_SIZE_H) n = 3'd2;
    else                         n = MEM_SIZE_W[2:0];
    return n;
  endfunction

  function automatic data_t extend_load(input data_t raw, input logic [2:0] n, input logic sgn);
    data_t r;
    case (n)
      3'd1:    r = {{24{sgn & raw[7]}},  raw[7:0]};
      3'd2:    r = {{16{sgn & raw[15]}}, raw[15:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Requester and RAM-side signals of the memory controller, bundled as one bus.
// The controller takes the slave view; requesters and the RAM model take the master view.
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;

  logic       in_rob_xbp;

  logic       in_if_flag;
  addr_t      in_if_addr;
  logic       out_if_done;
  data_t      out_if_data;

  logic       in_lsb_flag;
  addr_t      in_lsb_addr;
  logic [5:0] in_lsb_size;
  logic       in_lsb_signed;
  logic       out_lsb_done;
  data_t      out_lsb_data;

  logic       in_rob_flag;
  addr_t      in_rob_addr;
  logic [5:0] in_rob_size;
  data_t      in_rob_data;
  logic       out_rob_done;

  logic [7:0] mem_din;
  logic [7:0] mem_dout;
  addr_t      mem_a;
  logic       mem_wr;
  logic       io_buffer_full;

  modport slave (
    input  in_rob_xbp,
    input  in_if_flag, in_if_addr,
    output out_if_done, out_if_data,
    input  in_lsb_flag, in_lsb_addr, in_lsb_size, in_lsb_signed,
    output out_lsb_done, out_lsb_data,
    input  in_rob_flag, in_rob_addr, in_rob_size, in_rob_data,
    output out_rob_done,
    input  mem_din, io_buffer_full,
    output mem_dout, mem_a, mem_wr
  );

  modport master (
    output in_rob_xbp,
    output in_if_flag, in_if_addr,
    input  out_if_done, out_if_data,
    output in_lsb_flag, in_lsb_addr, in_lsb_size, in_lsb_signed,
    input  out_lsb_done, out_lsb_data,
    output in_rob_flag, in_rob_addr, in_rob_size, in_rob_data,
    input  out_rob_done,
    output mem_din, io_buffer_full,
    input  mem_dout, mem_a, mem_wr
  );

endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial owner of the unified RAM port: arbitrates store > load > fetch, splits each
// access into little-endian beats, reassembles/extends reads, honours flush and UART stalls.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0] RAM_IO_HI = RAM_IO_HI_DEFAULT
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rdy,
  mem_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_STORE = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;
  localparam logic [1:0] S_FETCH = 2'd3;

  logic [1:0] state;

  // Per-requester pending flag and captured request fields
  logic       if_pend, lsb_pend, rob_pend;
  addr_t      if_addr_q, lsb_addr_q, rob_addr_q;
  logic [5:0] lsb_size_q, rob_size_q;
  logic       lsb_sgn_q;
  data_t      rob_data_q;

  // Working copy of the transaction being serviced
  addr_t      cur_addr;
  logic [2:0] cur_n;
  logic       cur_sgn;
  data_t      cur_wdata;
  logic [2:0] cnt;
  data_t      rbuf;

  logic       flush, if_req, lsb_req, rob_req, io_stall;
  logic [1:0] grant;
  addr_t      if_addr_v, lsb_addr_v, rob_addr_v;
  logic [5:0] lsb_size_v, rob_size_v;
  logic       lsb_sgn_v;
  data_t      rob_data_v;
  data_t      rbuf_next;

  // A pulse arriving this cycle competes alongside the registered pending flags, so the
  // field views bypass the capture registers when the pulse is present.
  always_comb begin
    flush   = bus.in_rob_xbp;
    if_req  = !flush && (if_pend  || bus.in_if_flag);
    lsb_req = !flush && (lsb_pend || bus.in_lsb_flag);
    rob_req = rob_pend || bus.in_rob_flag;

    if (rob_req)      grant = S_STORE;
    else if (lsb_req) grant = S_LOAD;
    else if (if_req)  grant = S_FETCH;
    else              grant = S_IDLE;

    if_addr_v  = bus.in_if_flag  ? bus.in_if_addr    : if_addr_q;
    lsb_addr_v = bus.in_lsb_flag ? bus.in_lsb_addr   : lsb_addr_q;
    lsb_size_v = bus.in_lsb_flag ? bus.in_lsb_size   : lsb_size_q;
    lsb_sgn_v  = bus.in_lsb_flag ? bus.in_lsb_signed : lsb_sgn_q;
    rob_addr_v = bus.in_rob_flag ? bus.in_rob_addr   : rob_addr_q;
    rob_size_v = bus.in_rob_flag ? bus.in_rob_size   : rob_size_q;
    rob_data_v = bus.in_rob_flag ? bus.in_rob_data   : rob_data_q;
  end

  // Byte k of a read arrives one cycle after its address, i.e. while cnt == k+1.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    rbuf_next = rbuf;
    case (cnt)
      3'd1:    rbuf_next[7:0]   = bus.mem_din;
      3'd2:    rbuf_next[15:8]  = bus.mem_din;
      3'd3:    rbuf_next[23:16] = bus.mem_din;
      3'd4:    rbuf_next[31:24] = bus.mem_din;
      default: ;
    endcase
  end

  always_comb begin
    io_stall     = (state == S_STORE) && (cur_addr[17:16] == RAM_IO_HI) && bus.io_buffer_full;
    bus.mem_a    = ZERO_WORD;
    bus.mem_dout = 8'h00;
    bus.mem_wr   = FALSE;
    case (state)
      S_STORE: begin
        bus.mem_a    = cur_addr + addr_t'(cnt);
        bus.mem_dout = cur_wdata[{cnt[1:0], 3'b000} +: 8];
        bus.mem_wr   = rdy && !io_stall;
      end
      S_LOAD, S_FETCH: begin
        // The extra cycle that collects the last byte presents no new address.
        if (cnt < cur_n) bus.mem_a = cur_addr + addr_t'(cnt);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      if_pend          <= FALSE;
      lsb_pend         <= FALSE;
      rob_pend         <= FALSE;
      if_addr_q        <= ZERO_WORD;
      lsb_addr_q       <= ZERO_WORD;
      rob_addr_q       <= ZERO_WORD;
      lsb_size_q       <= '0;
      rob_size_q       <= '0;
      lsb_sgn_q        <= FALSE;
      rob_data_q       <= ZERO_WORD;
      cur_addr         <= ZERO_WORD;
      cur_n            <= '0;
      cur_sgn          <= FALSE;
      cur_wdata        <= ZERO_WORD;
      cnt              <= '0;
      rbuf             <= ZERO_WORD;
      bus.out_if_done  <= FALSE;
      bus.out_if_data  <= ZERO_WORD;
      bus.out_lsb_done <= FALSE;
      bus.out_lsb_data <= ZERO_WORD;
      bus.out_rob_done <= FALSE;
    end else if (rdy) begin
      // NOTE: state updates use non-blocking assignments so every register samples
      // pre-edge values regardless of statement order.
      bus.out_if_done  <= FALSE;
      bus.out_lsb_done <= FALSE;
      bus.out_rob_done <= FALSE;

      if (bus.in_if_flag) if_addr_q <= bus.in_if_addr;
      if (bus.in_lsb_flag) begin
        lsb_addr_q <= bus.in_lsb_addr;
        lsb_size_q <= bus.in_lsb_size;
        lsb_sgn_q  <= bus.in_lsb_signed;
      end
      if (bus.in_rob_flag) begin
        rob_addr_q <= bus.in_rob_addr;
        rob_size_q <= bus.in_rob_size;
        rob_data_q <= bus.in_rob_data;
      end

      // The winner's flag drops as it enters its state; a flush kills fetch/load requests.
      if_pend  <= if_req  && !(state == S_IDLE && grant == S_FETCH);
      lsb_pend <= lsb_req && !(state == S_IDLE && grant == S_LOAD);
      rob_pend <= rob_req && !(state == S_IDLE && grant == S_STORE);

      case (state)
        S_IDLE: begin
          if (grant != S_IDLE) begin
            state <= grant;
            cnt   <= '0;
            rbuf  <= ZERO_WORD;
            case (grant)
              S_STORE: begin
                cur_addr  <= rob_addr_v;
                cur_n     <= beat_count(rob_size_v);
                cur_sgn   <= FALSE;
                cur_wdata <= rob_data_v;
              end
              S_LOAD: begin
                cur_addr <= lsb_addr_v;
                cur_n    <= beat_count(lsb_size_v);
                cur_sgn  <= lsb_sgn_v;
              end
              default: begin
                cur_addr <= if_addr_v;
                cur_n    <= MEM_SIZE_W[2:0];
                cur_sgn  <= FALSE;
              end
            endcase
          end
        end

        S_STORE: begin
          if (!io_stall) begin
            if (cnt == cur_n - 3'd1) begin
              bus.out_rob_done <= TRUE;
              state            <= S_IDLE;
              cnt              <= '0;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
        end

        S_LOAD, S_FETCH: begin
          if (flush) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            rbuf <= rbuf_next;
            if (cnt == cur_n) begin
              state <= S_IDLE;
              cnt   <= '0;
              if (state == S_LOAD) begin
                bus.out_lsb_done <= TRUE;
                bus.out_lsb_data <= extend_load(rbuf_next, cur_n, cur_sgn);
              end else begin
                bus.out_if_done <= TRUE;
                bus.out_if_data <= rbuf_next;
              end
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: a byte RAM model answers the port one cycle late and a
// golden byte map predicts every load/fetch result and done latency from the access rules.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rdy;

  mem_ctrl_if bus();

  mem_ctrl dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int errors   = 0;
  int wr_count = 0;

  logic [7:0] ram  [logic [31:0]];
  logic [7:0] gold [logic [31:0]];
  logic [5:0] size_pool [6] = '{6'd1, 6'd2, 6'd4, 6'd0, 6'd3, 6'd6};

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return init_byte(a);
  endfunction

  function automatic logic [7:0] gold_rd(input logic [31:0] a);
    if (gold.exists(a)) return gold[a];
    return init_byte(a);
  endfunction

  // RAM model: writes land at the edge, read data appears the cycle after the address.
  always @(posedge clk) begin
    if (bus.mem_wr) begin
      ram[bus.mem_a] = bus.mem_dout;
      wr_count++;
    end
    bus.mem_din <= ram_rd(bus.mem_a);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int beats(input logic [5:0] size);
    if (size == 6'd1) return 1;
    if (size == 6'd2) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input int n, input logic sgn);
    logic [31:0] v;
    logic [31:0] mask;
    v = 32'h0;
    for (int k = 0; k < n; k++) v |= 32'(gold_rd(a + 32'(k))) << (8 * k);
    if (n < 4) begin
      mask = (32'd1 << (8 * n)) - 32'd1;
      if (sgn && v[8*n-1]) v |= ~mask;
    end
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input int n, input logic [31:0] data);
    for (int k = 0; k < n; k++) gold[a + 32'(k)] = 8'(data >> (8 * k));
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    ram[a]  = b;
    gold[a] = b;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_reqs();
    bus.in_if_flag  = 1'b0;
    bus.in_lsb_flag = 1'b0;
    bus.in_rob_flag = 1'b0;
    bus.in_rob_xbp  = 1'b0;
  endtask

  task automatic issue_fetch(input logic [31:0] a);
    bus.in_if_flag = 1'b1;
    bus.in_if_addr = a;
  endtask

  task automatic issue_load(input logic [31:0] a, input logic [5:0] size, input logic sgn);
    bus.in_lsb_flag   = 1'b1;
    bus.in_lsb_addr   = a;
    bus.in_lsb_size   = size;
    bus.in_lsb_signed = sgn;
  endtask

  task automatic issue_store(input logic [31:0] a, input logic [5:0] size, input logic [31:0] d);
    bus.in_rob_flag = 1'b1;
    bus.in_rob_addr = a;
    bus.in_rob_size = size;
    bus.in_rob_data = d;
  endtask

  function automatic logic done_of(input int which);
    case (which)
      0:       return bus.out_rob_done;
      1:       return bus.out_lsb_done;
      default: return bus.out_if_done;
    endcase
  endfunction

  // Request was raised in the current cycle (cycle 0); lat is the cycle of done, -1 on timeout.
  task automatic wait_done(input int which, input int budget, output int lat);
    lat = -1;
    for (int k = 1; k <= budget; k++) begin
      tick();
      if (k == 1) clear_reqs();
      if (done_of(which)) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_load(input string tag, input logic [31:0] a, input logic [5:0] size,
                          input logic sgn, output logic [31:0] got);
    int n;
    int lat;
    logic [31:0] exp;
    n   = beats(size);
    exp = model_read(a, n, sgn);
    issue_load(a, size, sgn);
    wait_done(1, 20, lat);
    got = bus.out_lsb_data;
    check({tag, " latency"}, lat, n + 2);
    check({tag, " data"}, got, exp);
  endtask

  task automatic run_fetch(input string tag, input logic [31:0] a, output logic [31:0] got);
    int lat;
    logic [31:0] exp;
    exp = model_read(a, 4, 1'b0);
    issue_fetch(a);
    wait_done(2, 20, lat);
    got = bus.out_if_data;
    check({tag, " latency"}, lat, 6);
    check({tag, " data"}, got, exp);
  endtask

  task automatic run_store(input string tag, input logic [31:0] a, input logic [5:0] size,
                           input logic [31:0] d);
    int n;
    int lat;
    n = beats(size);
    issue_store(a, size, d);
    wait_done(0, 20, lat);
    check({tag, " latency"}, lat, n + 1);
    model_store(a, n, d);
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] d_ld, d_if;
    int n_st, n_ld, n_if, c_st, c_ld, c_if;
    int t_st, t_ld, t_if;
    int w0, c_io;
    int op, n;
    logic [31:0] a, d;
    logic [5:0] sz;
    logic sg;

    rst = 1'b1;
    rdy = 1'b0;
    clear_reqs();
    bus.in_if_addr     = '0;
    bus.in_lsb_addr    = '0;
    bus.in_lsb_size    = '0;
    bus.in_lsb_signed  = 1'b0;
    bus.in_rob_addr    = '0;
    bus.in_rob_size    = '0;
    bus.in_rob_data    = '0;
    bus.io_buffer_full = 1'b0;

    // Reset is applied with rdy low: it must still take effect.
    repeat (3) tick();
    check("reset mem_a", bus.mem_a, 32'h0);
    check("reset mem_wr", 32'(bus.mem_wr), 32'h0);
    check("reset mem_dout", 32'(bus.mem_dout), 32'h0);
    check("reset dones", {29'h0, bus.out_if_done, bus.out_lsb_done, bus.out_rob_done}, 32'h0);
    check("reset if_data", bus.out_if_data, 32'h0);
    check("reset lsb_data", bus.out_lsb_data, 32'h0);
    rst = 1'b0;
    rdy = 1'b1;
    tick();

    preload(32'h100, 8'h13);
    preload(32'h101, 8'h05);
    preload(32'h102, 8'h00);
    preload(32'h103, 8'h00);
    preload(32'h200, 8'h80);
    preload(32'h201, 8'hFF);

    // Fetch: address beats in cycles 1-4, done in cycle 6
    issue_fetch(32'h100);
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 1) clear_reqs();
      if (k <= 4) begin
        check("fetch mem_a", bus.mem_a, 32'h100 + 32'(k - 1));
        check("fetch mem_wr", 32'(bus.mem_wr), 32'h0);
      end
      if (k >= 6) check("fetch idle mem_a", bus.mem_a, 32'h0);
      check("fetch done timing", 32'(bus.out_if_done), (k == 6) ? 32'h1 : 32'h0);
      if (k == 6) check("fetch data", bus.out_if_data, 32'h0000_0513);
    end

    // Sign/zero extension
    run_load("lb signed", 32'h200, 6'd1, 1'b1, got);
    check("lb signed value", got, 32'hFFFF_FF80);
    run_load("lb unsigned", 32'h200, 6'd1, 1'b0, got);
    check("lb unsigned value", got, 32'h0000_0080);
    run_load("lh signed", 32'h200, 6'd2, 1'b1, got);
    check("lh signed value", got, 32'hFFFF_FF80);

    // Store word: four write beats, done in cycle 5, then read back
    issue_store(32'h300, 6'd4, 32'hDEAD_BEEF);
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) clear_reqs();
      if (k <= 4) begin
        check("sw mem_wr", 32'(bus.mem_wr), 32'h1);
        check("sw mem_a", bus.mem_a, 32'h300 + 32'(k - 1));
        check("sw mem_dout", 32'(bus.mem_dout), (32'hDEAD_BEEF >> (8 * (k - 1))) & 32'hFF);
      end else begin
        check("sw idle mem_wr", 32'(bus.mem_wr), 32'h0);
      end
      check("sw done timing", 32'(bus.out_rob_done), (k == 5) ? 32'h1 : 32'h0);
    end
    model_store(32'h300, 4, 32'hDEAD_BEEF);
    run_load("lw readback", 32'h300, 6'd4, 1'b0, got);
    check("lw readback value", got, 32'hDEAD_BEEF);

    // Simultaneous requests: store, then load, then fetch, one idle cycle apart
    issue_store(32'h400, 6'd4, 32'h1122_3344);
    issue_load(32'h200, 6'd2, 1'b1);
    issue_fetch(32'h100);
    t_st = 1 + 4;
    t_ld = t_st + 1 + (2 + 1);
    t_if = t_ld + 1 + (4 + 1);
    n_st = 0; n_ld = 0; n_if = 0; c_st = -1; c_ld = -1; c_if = -1; d_ld = '0; d_if = '0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k == 1) clear_reqs();
      if (bus.out_rob_done) begin n_st++; c_st = k; end
      if (bus.out_lsb_done) begin n_ld++; c_ld = k; d_ld = bus.out_lsb_data; end
      if (bus.out_if_done)  begin n_if++; c_if = k; d_if = bus.out_if_data; end
    end
    model_store(32'h400, 4, 32'h1122_3344);
    check("arb store count", n_st, 1);
    check("arb load count", n_ld, 1);
    check("arb fetch count", n_if, 1);
    check("arb store cycle", c_st, t_st);
    check("arb load cycle", c_ld, t_ld);
    check("arb fetch cycle", c_if, t_if);
    check("arb load data", d_ld, 32'hFFFF_FF80);
    check("arb fetch data", d_if, 32'h0000_0513);

    // Flush on the 2nd byte of a word load while a store waits; a same-cycle fetch is dropped
    issue_load(32'h300, 6'd4, 1'b0);
    n_st = 0; n_ld = 0; n_if = 0; c_st = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) begin
        bus.in_lsb_flag = 1'b0;
        issue_store(32'h500, 6'd2, 32'h0000_CAFE);
      end
      if (k == 2) begin
        bus.in_rob_flag = 1'b0;
        check("flush 2nd byte addr", bus.mem_a, 32'h301);
        bus.in_rob_xbp = 1'b1;
        issue_fetch(32'h100);
      end
      if (k == 3) clear_reqs();
      if (bus.out_rob_done) begin n_st++; c_st = k; end
      if (bus.out_lsb_done) n_ld++;
      if (bus.out_if_done)  n_if++;
    end
    model_store(32'h500, 2, 32'h0000_CAFE);
    check("flush load done count", n_ld, 0);
    check("flush dropped fetch count", n_if, 0);
    check("flush store count", n_st, 1);
    check("flush store cycle", c_st, 3 + 1 + 2);
    run_fetch("fetch after flush", 32'h100, got);
    run_load("store after flush readback", 32'h500, 6'd2, 1'b0, got);
    check("store after flush value", got, 32'h0000_CAFE);

    // UART back-pressure on an IO-region byte store
    run_store("io unstalled", 32'h0003_0000, 6'd1, 32'h41);
    issue_store(32'h0003_0000, 6'd1, 32'h41);
    bus.io_buffer_full = 1'b1;
    w0   = wr_count;
    c_io = -1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) clear_reqs();
      if (k == 4) begin
        bus.io_buffer_full = 1'b0;
        #1;
      end
      if (k <= 3) check("io stalled mem_wr", 32'(bus.mem_wr), 32'h0);
      if (k == 4) begin
        check("io resume mem_wr", 32'(bus.mem_wr), 32'h1);
        check("io resume mem_dout", 32'(bus.mem_dout), 32'h41);
        check("io resume mem_a", bus.mem_a, 32'h0003_0000);
      end
      if (bus.out_rob_done && c_io < 0) c_io = k;
    end
    check("io stalled done cycle", c_io, (1 + 1) + 3);
    check("io write count", wr_count - w0, 1);

    // rdy low freezes the controller and suppresses writes
    issue_store(32'h600, 6'd1, 32'h77);
    c_io = -1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) begin
        clear_reqs();
        rdy = 1'b0;
      end
      if (k == 3) rdy = 1'b1;
      #1;
      if (k <= 2) check("rdy low mem_wr", 32'(bus.mem_wr), 32'h0);
      if (k == 3) begin
        check("rdy resume mem_wr", 32'(bus.mem_wr), 32'h1);
        check("rdy resume mem_a", bus.mem_a, 32'h600);
      end
      if (bus.out_rob_done && c_io < 0) c_io = k;
    end
    model_store(32'h600, 1, 32'h77);
    check("rdy store done cycle", c_io, 4);

    // Address wrap across 2^32
    run_load("wrap load", 32'hFFFF_FFFE, 6'd4, 1'b0, got);

    // Randomised serial traffic against the golden byte map
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 2));
      a  = 32'h1000 + 32'($urandom_range(0, 31));
      sz = size_pool[$urandom_range(0, 5)];
      sg = 1'($urandom_range(0, 1));
      d  = $urandom;
      n  = beats(sz);
      case (op)
        0:       run_store("rand store", a, sz, d);
        1:       run_load("rand load", a, sz, sg, got);
        default: run_fetch("rand fetch", a, got);
      endcase
      if (n == 0) check("rand beat count", 32'(n), 32'h1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
